subckt_sweep_ctrl: RTL
======================

# subckt_sweep_ctrl

Sequencer that drives a small combinational sub-circuit (up to 8 primary inputs, one primary output) through exhaustive input sweeps and collects switching-activity statistics for power characterisation. It applies every input code in binary or Gray order and waits a programmable settle time before sampling the response. It accumulates output ones, output toggles, input bit-flips and a response signature. It sits between the characterisation host, which uses a start/done handshake, and one sub-circuit instance under measurement.

## Interface
- NUM_IN, 4: sub-circuit input count (1..8); one sweep = 2^NUM_IN vectors
- CNT_W, 16: width of every statistic counter
- SIG_W, 16: signature width
- POLY, 16'h1021: signature feedback polynomial (SIG_W bits)
- SETTLE_CYC, 1: cycles each vector is held before sampling (>=1)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin run; sampled only in IDLE
- abort  input  1  terminate run; highest priority when busy
- gray_mode  input  1  1 = Gray order, 0 = binary; latched at start
- rep_count  input  8  sweeps per run; latched at start; 0 treated as 1
- vec_out  output  NUM_IN  stimulus to the sub-circuit inputs
- resp_in  input  1  sub-circuit output
- busy  output  1  run in progress
- done  output  1  one-cycle pulse on normal completion
- ones_cnt  output  CNT_W  samples with resp_in=1
- out_tog_cnt  output  CNT_W  resp changes between consecutive samples
- in_tog_cnt  output  CNT_W  total vec_out bit flips during the run
- signature  output  SIG_W  response signature

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE + start=1:
  - Latch gray_mode and rep_count.
  - Clear all counters, signature, index idx and sweep counter.
  - Set vec_out=0 and settle counter=SETTLE_CYC-1.
  - Go to SETTLE.
- Starting a run never counts input flips, even if the previous vec_out was nonzero.
- SETTLE: decrement the settle counter; when it reads 0, go to SAMPLE.
- SAMPLE (exactly one cycle):
  - ones_cnt += resp_in.
  - If this is not the first sample of the run and resp_in != prev_resp, out_tog_cnt++. Then prev_resp <= resp_in.
  - signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ resp_in.
  - If idx = 2^NUM_IN-1 and sweep = rep-1, go to DONE; vec_out holds.
  - Otherwise advance idx, wrapping to 0 and incrementing sweep at the end of a sweep. Set vec_out = code(idx_next), add popcount(vec_out ^ code(idx_next)) to in_tog_cnt, reload the settle counter, and go to SETTLE.
  - code(i) = gray_mode ? i ^ (i>>1) : i.
- DONE: done=1 for one cycle, busy=0, go to IDLE. Results and vec_out hold until the next start.
- abort=1 in SETTLE or SAMPLE: go to IDLE at the next edge. No done pulse; no update from that SAMPLE cycle. Counters and vec_out hold their current values.
- All counters saturate at 2^CNT_W-1 and never wrap.
- start while busy is ignored. abort in IDLE or DONE is ignored.

## Timing
- Reset values:
  - State IDLE.
  - vec_out, busy, done, all counters and signature = 0.
  - prev_resp = 0; sweep and idx = 0.
- busy = 1 in SETTLE and SAMPLE; 0 in IDLE and DONE. busy is registered, high the cycle after start is accepted.
- Each vector occupies SETTLE_CYC+1 cycles: SETTLE_CYC in SETTLE, then 1 in SAMPLE.
- resp_in is sampled on the SAMPLE-cycle edge; the sub-circuit path must settle within SETTLE_CYC cycles.
- Start accepted at edge 0: done is high in the cycle after edge rep*2^NUM_IN*(SETTLE_CYC+1) and low one edge later. A new start is accepted no earlier than the cycle after done.
- vec_out changes only on the SAMPLE-to-SETTLE edge and the start edge. It is glitch-free because it is registered.
- rst_n assertion mid-run forces the reset state immediately; no done pulse.

## Test plan
- NUM_IN=4, SETTLE_CYC=1, binary, rep=1, resp_in=vec_out[0] -> ones_cnt=8, out_tog_cnt=15, in_tog_cnt=26; done 32 cycles after start.
- Same setup, Gray order -> ones_cnt=8, out_tog_cnt=8, in_tog_cnt=15.
- rep=2: binary gives in_tog_cnt=56; Gray gives in_tog_cnt=31; rep=0 behaves as rep=1. resp_in=0 -> ones, toggles and signature all 0.
- SETTLE_CYC=3, Gray, rep=1 -> vec_out steady for 4 cycles per vector; done exactly 64 cycles after start; start pulsed mid-run has no effect.
- CNT_W=4, resp_in=1, rep=2 -> ones_cnt saturates at 15, not 0.
- abort after the 5th SAMPLE -> IDLE the next cycle, no done, ones_cnt frozen; rst_n low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/subckt_sweep_ctrl.sv
// subckt_sweep_ctrl: exhaustive input sweeper for power characterisation
// of a small combinational sub-circuit (binary/Gray order, settle, stats).
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start, abort     host control (start in IDLE, abort while busy)
//   gray_mode        1 = Gray code order, latched at start
//   rep_count        sweeps per run, latched at start (0 acts as 1)
//   vec_out          registered stimulus to the sub-circuit
//   resp_in          sub-circuit response
//   busy, done       run in progress / one-cycle completion pulse
//   ones_cnt         samples with resp_in = 1
//   out_tog_cnt      response changes between consecutive samples
//   in_tog_cnt       stimulus bit flips during the run
//   signature        response signature
module subckt_sweep_ctrl #(
  parameter int              NUM_IN     = 4,
  parameter int              CNT_W      = 16,
  parameter int              SIG_W      = 16,
  parameter logic [SIG_W-1:0] POLY      = 16'h1021,
  parameter int              SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              gray_mode,
  input  logic [7:0]        rep_count,
  output logic [NUM_IN-1:0] vec_out,
  input  logic              resp_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  ones_cnt,
  output logic [CNT_W-1:0]  out_tog_cnt,
  output logic [CNT_W-1:0]  in_tog_cnt,
  output logic [SIG_W-1:0]  signature
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int SCW =
    (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCW-1:0] SET_INIT =
    SCW'(SETTLE_CYC - 1);
  localparam logic [NUM_IN-1:0] IDX_LAST = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t state_q;
  state_t state_d;

  logic              gray_q;
  logic [7:0]        rep_q;
  logic [7:0]        sweep_q;
  logic [NUM_IN-1:0] idx_q;
  logic [SCW-1:0]    set_q;
  logic [NUM_IN-1:0] vec_q;
  logic [CNT_W-1:0]  ones_q;
  logic [CNT_W-1:0]  otog_q;
  logic [CNT_W-1:0]  itog_q;
  logic [SIG_W-1:0]  sig_q;
  logic              prev_q;
  logic              first_q;
  logic              busy_q;
  logic              done_q;

  function automatic logic [3:0] popcnt(
    input logic [NUM_IN-1:0] v
  );
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_IN; i++)
      c = c + {3'd0, v[i]};
    return c;
  endfunction

  logic [NUM_IN-1:0] idx_nx;
  logic [NUM_IN-1:0] code_nx;
  logic [3:0]        flips;
  logic [CNT_W:0]    itog_sum;
  logic [CNT_W-1:0]  itog_sat;
  logic [CNT_W-1:0]  ones_nx;
  logic [CNT_W-1:0]  otog_nx;
  logic              tog_hit;
  logic [SIG_W-1:0]  sig_fb;
  logic [SIG_W-1:0]  sig_nx;
  logic              last_vec;
  logic              idx_wrap;
  logic              set_zero;
  logic              active;

  logic do_start;
  logic do_settle;
  logic do_sample;
  logic do_abort;

  assign active   = (state_q == SETTLE) ||
                    (state_q == SAMPLE);
  assign set_zero = (set_q == '0);
  assign idx_wrap = (idx_q == IDX_LAST);
  assign last_vec = idx_wrap &&
                    (sweep_q == rep_q - 8'd1);

  assign idx_nx  = idx_q + NUM_IN'(1);
  assign code_nx = gray_q ? (idx_nx ^ (idx_nx >> 1))
                          : idx_nx;
  assign flips   = popcnt(vec_q ^ code_nx);

  // Widen by one bit so the carry flags saturation.
  assign itog_sum = {1'b0, itog_q} +
                    (CNT_W + 1)'(flips);
  assign itog_sat = itog_sum[CNT_W] ? CNT_MAX
                                    : itog_sum[CNT_W-1:0];

  assign ones_nx = (resp_in && (ones_q != CNT_MAX))
                   ? ones_q + CNT_W'(1) : ones_q;

  // No toggle can be seen on the run's first sample.
  assign tog_hit = !first_q && (resp_in != prev_q);
  assign otog_nx = (tog_hit && (otog_q != CNT_MAX))
                   ? otog_q + CNT_W'(1) : otog_q;

  assign sig_fb = sig_q[SIG_W-1] ? POLY : '0;
  assign sig_nx = {sig_q[SIG_W-2:0], 1'b0} ^ sig_fb ^
                  {{(SIG_W-1){1'b0}}, resp_in};

  assign do_start  = (state_q == IDLE) && start;
  assign do_abort  = active && abort;
  assign do_settle = (state_q == SETTLE) && !abort &&
                     !set_zero;
  assign do_sample = (state_q == SAMPLE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SETTLE;
      end
      SETTLE: begin
        if (abort)         state_d = IDLE;
        else if (set_zero) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (abort)         state_d = IDLE;
        else if (last_vec) state_d = DONE;
        else               state_d = SETTLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q  <= 1'b0;
      rep_q   <= 8'd1;
      sweep_q <= '0;
      idx_q   <= '0;
      set_q   <= '0;
      vec_q   <= '0;
      ones_q  <= '0;
      otog_q  <= '0;
      itog_q  <= '0;
      sig_q   <= '0;
      prev_q  <= 1'b0;
      first_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        do_start: begin
          gray_q  <= gray_mode;
          rep_q   <= (rep_count == 8'd0) ? 8'd1
                                         : rep_count;
          sweep_q <= '0;
          idx_q   <= '0;
          set_q   <= SET_INIT;
          vec_q   <= '0;
          ones_q  <= '0;
          otog_q  <= '0;
          itog_q  <= '0;
          sig_q   <= '0;
          prev_q  <= 1'b0;
          first_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        do_abort: begin
          busy_q <= 1'b0;
        end
        do_settle: begin
          set_q <= set_q - SCW'(1);
        end
        do_sample: begin
          ones_q  <= ones_nx;
          otog_q  <= otog_nx;
          sig_q   <= sig_nx;
          prev_q  <= resp_in;
          first_q <= 1'b0;
          if (last_vec) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            idx_q  <= idx_nx;
            if (idx_wrap)
              sweep_q <= sweep_q + 8'd1;
            vec_q  <= code_nx;
            itog_q <= itog_sat;
            set_q  <= SET_INIT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign vec_out     = vec_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ones_cnt    = ones_q;
  assign out_tog_cnt = otog_q;
  assign in_tog_cnt  = itog_q;
  assign signature   = sig_q;

endmodule
